// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the 8-way round-robin arbiter
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_REQ-1:0] req_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic req_t onehot(input sel_t idx);
    return req_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick: first set bit of mask searching from last+1
module rr_pick8
  import arb_pkg::*;
(
  input  req_t       mask,
  input  sel_t       last,
  output sel_t       idx,
  output logic       found
);

  sel_t start;
  req_t rot;
  sel_t k;

  assign start = last + sel_t'(1);

  // rot[0] is the highest-priority candidate; 3-bit index arithmetic wraps modulo 8
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = mask[start + sel_t'(i)];
    end
  end

  always_comb begin
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) k = sel_t'(i);
    end
  end

  assign found = |rot;
  assign idx   = start + k;

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - round-robin arbiter for an 8:1 shared select mux with tenure limit
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic [7:0] owner_cnt
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  req_t             gnt_q, gnt_d;
  sel_t             sel_q, sel_d;
  sel_t             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  req_t pick_mask;
  sel_t pick_last;
  sel_t pick_idx;
  logic pick_found;

  rr_pick8 u_pick (
    .mask  (pick_mask),
    .last  (pick_last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= sel_t'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // While busy, the owner is masked and the search starts after it; this one
  // setting serves both release and timeout arbitration.
  always_comb begin
    pick_mask = req;
    pick_last = last_q;
    if (state_q == BUSY) begin
      pick_mask = req & ~gnt_q;
      pick_last = sel_q;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!req[sel_q]) begin
          last_d = sel_q;
          cnt_d  = '0;
          if (pick_found) begin
            gnt_d = onehot(pick_idx);
            sel_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (pick_found) begin
            last_d = sel_q;
            gnt_d  = onehot(pick_idx);
            sel_d  = pick_idx;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign valid     = (state_q == BUSY);
  assign owner_cnt = 8'(cnt_q);

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8 against a behavioural model
module tb_rr_arbiter8;

  localparam int MH = 16;

  logic       clk;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic [7:0] owner_cnt;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .valid     (valid),
    .owner_cnt (owner_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 when idle), pointer, tenure count, held select.
  int m_own  = -1;
  int m_last = 7;
  int m_cnt  = 0;
  int m_sel  = 0;

  function automatic int search(input logic [7:0] mask, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (mask[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int w;
    logic [7:0] mk;
    if (!reset_n) begin
      m_own = -1; m_last = 7; m_cnt = 0; m_sel = 0;
    end else if (m_own < 0) begin
      w = search(req, m_last);
      if (w >= 0) begin m_own = w; m_sel = w; m_cnt = 0; end
    end else if (!req[m_own]) begin
      m_last = m_own;
      m_cnt  = 0;
      w = search(req, m_own);
      if (w >= 0) begin m_own = w; m_sel = w; end
      else m_own = -1;
    end else if (m_cnt == MH - 1) begin
      m_cnt = 0;
      mk = req;
      mk[m_own] = 1'b0;
      w = search(mk, m_own);
      if (w >= 0) begin m_last = m_own; m_own = w; m_sel = w; end
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    check("model_gnt", int'(gnt), (m_own < 0) ? 0 : (1 << m_own));
    check("model_sel", int'(sel), m_sel);
    check("model_valid", int'(valid), (m_own >= 0) ? 1 : 0);
    check("model_cnt", int'(owner_cnt), m_cnt);
    check("inv_onehot0", int'($onehot0(gnt)), 1);
    check("inv_valid_or", int'(valid), int'(|gnt));
    if (valid) check("inv_gnt_sel", int'(gnt[sel]), 1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 8'h00;
    tick(1);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    req     = 8'h00;
    #1 reset_n = 1'b0;
    tick(2);
    check("rst_gnt", int'(gnt), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_cnt", int'(owner_cnt), 0);
    reset_n = 1'b1;

    // single request, one-cycle latency, release to idle
    req = 8'h01;
    tick(1);
    check("t1_gnt", int'(gnt), 8'h01);
    check("t1_sel", int'(sel), 0);
    check("t1_valid", int'(valid), 1);
    req = 8'h00;
    tick(1);
    check("t1_idle_gnt", int'(gnt), 0);
    check("t1_idle_valid", int'(valid), 0);
    check("t1_idle_sel", int'(sel), 0);

    // full rotation with back-to-back handoff
    do_reset();
    req = 8'hFF;
    tick(1);
    for (int k = 0; k < 9; k++) begin
      check("t2_sel", int'(sel), k % 8);
      check("t2_gnt", int'(gnt), 1 << (k % 8));
      tick(1);
      req[k % 8] = 1'b0;
      tick(1);
      req[k % 8] = 1'b1;
    end

    // timeout preemption by a waiting requester
    do_reset();
    req = 8'h08;
    tick(1);
    check("t3_first", int'(gnt), 8'h08);
    tick(4);
    req[5] = 1'b1;
    tick(11);
    check("t3_last_gnt", int'(gnt), 8'h08);
    check("t3_last_cnt", int'(owner_cnt), 15);
    tick(1);
    check("t3_pre_gnt", int'(gnt), 8'h20);
    check("t3_pre_sel", int'(sel), 5);
    check("t3_pre_cnt", int'(owner_cnt), 0);
    tick(2);
    check("t3_hold5", int'(gnt), 8'h20);
    req[5] = 1'b0;
    tick(1);
    check("t3_back3", int'(gnt), 8'h08);
    check("t3_back3_sel", int'(sel), 3);

    // lone requester renews tenure
    do_reset();
    req = 8'h40;
    tick(16);
    check("t4_cnt15", int'(owner_cnt), 15);
    check("t4_gnt15", int'(gnt), 8'h40);
    tick(1);
    check("t4_cnt0", int'(owner_cnt), 0);
    check("t4_gnt0", int'(gnt), 8'h40);

    // release coincident with new requests, search wraps
    do_reset();
    req = 8'h04;
    tick(2);
    check("t5_own2", int'(sel), 2);
    req = 8'h82;
    tick(1);
    check("t5_gnt7", int'(gnt), 8'h80);
    check("t5_sel7", int'(sel), 7);
    req = 8'h02;
    tick(1);
    check("t5_gnt1", int'(gnt), 8'h02);
    check("t5_sel1", int'(sel), 1);

    // asynchronous reset mid-tenure
    req = 8'h2A;
    tick(1);
    check("t6_own1", int'(gnt), 8'h02);
    #1 reset_n = 1'b0;
    #1;
    check("t6_async_gnt", int'(gnt), 0);
    check("t6_async_valid", int'(valid), 0);
    check("t6_async_sel", int'(sel), 0);
    #4 reset_n = 1'b1;
    tick(1);
    check("t6_after_gnt", int'(gnt), 8'h02);
    check("t6_after_sel", int'(sel), 1);

    req = 8'h00;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one 8-input shared path among 8 requesters. The path is built from an 8:1 select mux, replicated per bit.
- Produces a one-hot grant and the 3-bit mux select code. Also enforces a maximum tenure, after which the owner is preempted.
- Sits between requesting units (register-file read ports, memory clients) and the shared select mux.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant while others wait. Legal range 2..256.
- N_REQ, 8, number of requesters. Fixed at 8 to match the 3-bit select; not overridable.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  8  request vector; bit i held high by requester i for as long as it needs the path
- gnt  output  8  one-hot grant, registered; all zeros when idle
- sel  output  3  mux select code, registered; equals the index of the set gnt bit when valid=1
- valid  output  1  high when some requester owns the path
- owner_cnt  output  8  cycles the current owner has held the grant, for debug and performance counters

Behaviour:
- Reset (reset_n=0, takes effect immediately, asynchronously):
  - gnt=0, sel=0, valid=0, owner_cnt=0, state=IDLE.
  - Round-robin pointer last=7, so requester 0 has first priority after reset.
- Priority order: search indices last+1, last+2, … modulo 8; the first set bit of the candidate mask wins.
- IDLE:
  - If req!=0, go to BUSY on the next edge. gnt gets the one-hot winner, sel its index, valid=1, owner_cnt=0.
  - Latency from req to gnt is exactly 1 cycle.
  - If req==0, stay in IDLE; sel keeps its last value so the mux output stays stable.
- BUSY, owner o, per edge:
  - Release: req[o]=0.
    - last<=o.
    - If req has any other bit set, grant the next winner directly, with no idle cycle, and set owner_cnt=0.
    - Otherwise go to IDLE: gnt=0, valid=0, sel holds.
  - Timeout: req[o]=1 and owner_cnt==MAX_HOLD-1.
    - If any other req bit is set: last<=o, arbitrate with bit o masked out, grant that winner, owner_cnt=0.
    - If no other request: keep the grant and set owner_cnt=0 (tenure renewed).
  - Otherwise: hold gnt and sel, owner_cnt<=owner_cnt+1.
- owner_cnt never exceeds MAX_HOLD-1. Counter width is clog2(MAX_HOLD) bits, zero-extended onto the 8-bit port.
- Invariants, every cycle:
  - $onehot0(gnt).
  - valid == |gnt.
  - valid implies gnt[sel]==1.
  - gnt changes only on a rising clk edge or on reset assertion.
- Simultaneous events:
  - A new request arriving in the same cycle as a release takes part in that cycle's arbitration.
  - A release and a timeout in the same cycle are treated as a release.
- Reset mid-tenure: grant is dropped immediately. After deassertion, arbitration restarts from last=7 on the first edge with req!=0.
- State encoding: 2 states (IDLE, BUSY). Grant takes effect at the clock edge; no combinational path from req to gnt or sel.

Decomposition:
- Package arb_pkg:
  - Constants: N_REQ=8, SEL_W=3.
  - Typedefs: sel_t (logic [2:0]), req_t (logic [7:0]), arb_state_t enum {IDLE, BUSY}.
- Sub-module rr_pick8 (combinational):
  - Inputs: req_t mask, sel_t last.
  - Outputs: sel_t idx, logic found.
  - Implementation: rotate, fixed-priority pick, unrotate.
  - Instantiated once; the timeout and release paths share it by masking the owner bit before the call.

Test Plan:
- Reset then req=8'b0000_0001 → one cycle later gnt=8'h01, sel=0, valid=1. Drop req → next edge gnt=0, valid=0, sel stays 0.
- req=8'hFF held, each owner drops its req after 2 cycles and reasserts one cycle later → grant order 0,1,2,…,7,0 with no idle cycles between owners.
- MAX_HOLD=16, req[3] held continuously, req[5] raised at cycle 4 → req[3] granted for 16 cycles, then gnt=8'h20, sel=5. req[3] regrants only after req[5] releases.
- req[6] held alone past MAX_HOLD → gnt stays 8'h40 and owner_cnt wraps 15→0, with no glitch on gnt.
- Owner 2 releases in the same cycle that req[1] and req[7] rise → next winner 7 (search starts at 3, wraps), then 1.
- reset_n pulsed low mid-tenure for a half cycle → gnt, valid and sel go to 0 asynchronously. The first grant after reset goes to the lowest set index.
